// File: rtl/cache_dir_array.sv
// ---------------------------------------------------------------------------
// cache_dir_array
//
// Directory storage for one cache. Each index holds one {tag, line state}
// entry. The block answers the cache controller through the rsp side of
// cache_dir_if:
//   - lookup: the entry at dir.index is registered onto current_tag /
//     current_state, so it is visible one cycle after the index is presented.
//   - write:  dir.write stores {next_tag, next_state} at dir.index in one
//     cycle. A lookup of the same index in that cycle returns the new data.
// After reset or a flush pulse, every entry is cleared to INVALID by a
// sequential sweep over all indices. init_done is low during the sweep.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   dir        cache_dir_if.rsp: index, next_tag, next_state, write in;
//              current_tag, current_state out
//   flush      one-cycle pulse, invalidate every entry
//   init_done  high while the directory accepts requests
// ---------------------------------------------------------------------------

package cache_pkg;
    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } line_state_t;
endpackage

interface cache_dir_if #(
    parameter int INDEX_WIDTH = 7,
    parameter int TAG_WIDTH   = 20
);
    import cache_pkg::*;

    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   next_tag;
    line_state_t            next_state;
    logic                   write;
    logic [TAG_WIDTH-1:0]   current_tag;
    line_state_t            current_state;

    modport req (
        output index, next_tag, next_state, write,
        input  current_tag, current_state
    );

    modport rsp (
        input  index, next_tag, next_state, write,
        output current_tag, current_state
    );
endinterface

module cache_dir_array
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 7,
    parameter int TAG_WIDTH   = 20
) (
    input  logic    clk,
    input  logic    rst,
    cache_dir_if.rsp dir,
    input  logic    flush,
    output logic    init_done
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] SWEEP_LAST = {INDEX_WIDTH{1'b1}};

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        line_state_t          state;
    } dir_entry_t;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } fsm_t;

    localparam dir_entry_t EMPTY_ENTRY = '{tag: '0, state: INVALID};

    fsm_t                   state_reg;
    fsm_t                   state_next;
    logic [INDEX_WIDTH-1:0] sweep_idx_reg;
    logic [INDEX_WIDTH-1:0] sweep_idx_next;
    logic                   init_done_reg;
    logic                   init_done_next;

    // Single write port shared by the sweep and by controller writes.
    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_addr;
    dir_entry_t             wr_data;
    logic                   lookup_en;

    dir_entry_t             mem [DEPTH];
    dir_entry_t             rd_reg;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SWEEP;
            sweep_idx_reg <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sweep_idx_reg <= sweep_idx_next;
            init_done_reg <= init_done_next;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        sweep_idx_next = sweep_idx_reg;
        case (state_reg)
            SWEEP: begin
                // Wraps back to 0 on the last entry, ready for the next sweep.
                sweep_idx_next = sweep_idx_reg + 1'b1;
                if (sweep_idx_reg == SWEEP_LAST) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (flush) begin
                    state_next     = SWEEP;
                    sweep_idx_next = '0;
                end
            end
            default: begin
                state_next     = SWEEP;
                sweep_idx_next = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output / datapath control
    // ---------------------------------------------------------------
    always_comb begin
        wr_en          = 1'b0;
        wr_addr        = dir.index;
        wr_data        = '{tag: dir.next_tag, state: dir.next_state};
        lookup_en      = 1'b0;
        init_done_next = 1'b0;
        case (state_reg)
            SWEEP: begin
                // Controller writes are dropped; the port belongs to the sweep.
                wr_en          = 1'b1;
                wr_addr        = sweep_idx_reg;
                wr_data        = EMPTY_ENTRY;
                init_done_next = (sweep_idx_reg == SWEEP_LAST);
            end
            READY: begin
                // A flush outranks a write presented in the same cycle.
                wr_en          = dir.write & ~flush;
                lookup_en      = ~flush;
                init_done_next = ~flush;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Storage: single-port RAM, write-first registered read
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // In READY the write address is dir.index, so a write and a lookup in
    // the same cycle always hit the same entry; returning wr_data gives
    // write-first behaviour without a second read port.
    always_ff @(posedge clk) begin
        if (rst || !lookup_en) begin
            rd_reg <= EMPTY_ENTRY;
        end else if (wr_en) begin
            rd_reg <= wr_data;
        end else begin
            rd_reg <= mem[dir.index];
        end
    end

    assign dir.current_tag   = rd_reg.tag;
    assign dir.current_state = rd_reg.state;
    assign init_done         = init_done_reg;

endmodule

// File: tb/tb_cache_dir_array.sv
// ---------------------------------------------------------------------------
// tb_cache_dir_array
//
// Bench for cache_dir_array with INDEX_WIDTH=7, TAG_WIDTH=20. A behavioural
// model (plain arrays plus a countdown for the clearing period) predicts
// init_done and the lookup outputs; a compare process checks them on every
// falling edge. Directed scenarios pin the model with literal expectations,
// then a randomized phase mixes lookups, writes, flushes and resets.
// ---------------------------------------------------------------------------
module tb_cache_dir_array;
    import cache_pkg::*;

    localparam int IW    = 7;
    localparam int TW    = 20;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic init_done;

    cache_dir_if #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dir_bus ();

    cache_dir_array #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .dir       (dir_bus),
        .flush     (flush),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    logic [TW-1:0] m_tag [DEPTH];
    line_state_t   m_st  [DEPTH];
    logic          m_ready;
    int            m_left;       // clearing cycles still to go
    logic [TW-1:0] e_tag;
    line_state_t   e_st;

    always @(posedge clk) begin
        if (rst || (m_ready && flush)) begin
            // Whole directory becomes invalid; nothing is observable until
            // the clearing period has elapsed, so clear it at once.
            for (int i = 0; i < DEPTH; i++) begin
                m_tag[i] <= '0;
                m_st[i]  <= INVALID;
            end
            m_ready <= 1'b0;
            m_left  <= DEPTH;
            e_tag   <= '0;
            e_st    <= INVALID;
        end else if (!m_ready) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_ready <= 1'b1;
            e_tag <= '0;
            e_st  <= INVALID;
        end else if (dir_bus.write) begin
            m_tag[dir_bus.index] <= dir_bus.next_tag;
            m_st[dir_bus.index]  <= dir_bus.next_state;
            e_tag <= dir_bus.next_tag;
            e_st  <= dir_bus.next_state;
        end else begin
            e_tag <= m_tag[dir_bus.index];
            e_st  <= m_st[dir_bus.index];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_init_done", 32'(init_done), 32'(m_ready));
            chk("cyc_tag", 32'(dir_bus.current_tag), 32'(e_tag));
            chk("cyc_state", 32'(dir_bus.current_state), 32'(e_st));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dir_bus.write = 1'b0;
        flush         = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic wr(input int idx, input logic [TW-1:0] tag, input line_state_t st);
        dir_bus.index      = IW'(idx);
        dir_bus.next_tag   = tag;
        dir_bus.next_state = st;
        dir_bus.write      = 1'b1;
        step();
        dir_bus.write = 1'b0;
        $display("tb: write idx=%0d tag=%05h state=%0d", idx, tag, st);
    endtask

    task automatic rd_chk(input string name, input int idx, input logic [TW-1:0] tag, input line_state_t st);
        dir_bus.index = IW'(idx);
        step();
        chk({name, "_tag"}, 32'(dir_bus.current_tag), 32'(tag));
        chk({name, "_state"}, 32'(dir_bus.current_state), 32'(st));
    endtask

    int n;
    int r;

    initial begin
        rst                = 1'b1;
        flush              = 1'b0;
        dir_bus.write      = 1'b0;
        dir_bus.index      = '0;
        dir_bus.next_tag   = '0;
        dir_bus.next_state = INVALID;

        // Reset state
        step(); step(); step();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_tag", 32'(dir_bus.current_tag), 32'd0);
        chk("rst_state", 32'(dir_bus.current_state), 32'(INVALID));

        // Reset release: init_done exactly 128 cycles later
        idle();
        wait_init(n);
        chk("init_latency", 32'(n), 32'd128);
        $display("tb: init after %0d cycles", n);
        for (int i = 0; i < DEPTH; i++) rd_chk("sweep_clear", i, '0, INVALID);

        // Write then read back; neighbour untouched
        wr(5, 20'hABCDE, MODIFIED);
        rd_chk("rd_idx5", 5, 20'hABCDE, MODIFIED);
        rd_chk("rd_idx6", 6, 20'h0, INVALID);

        // Write-first: old 0x11111 never seen when index 9 is rewritten
        wr(9, 20'h11111, SHARED);
        dir_bus.index = IW'(0);
        step();
        wr(9, 20'h12345, EXCLUSIVE);
        chk("wfirst_tag", 32'(dir_bus.current_tag), 32'h12345);
        chk("wfirst_state", 32'(dir_bus.current_state), 32'(EXCLUSIVE));
        rd_chk("wfirst_hold", 9, 20'h12345, EXCLUSIVE);

        // Write during sweep is dropped
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        wr(3, 20'hFFFFF, MODIFIED);
        wait_init(n);
        chk("init_after_rst", 32'(n), 32'd117);
        rd_chk("sweep_wr_drop", 3, '0, INVALID);

        // Flush with a concurrent write
        wr(0, 20'h00AAA, SHARED);
        wr(64, 20'h64646, EXCLUSIVE);
        wr(127, 20'h7F7F7, MODIFIED);
        dir_bus.index      = IW'(64);
        dir_bus.next_tag   = 20'h55555;
        dir_bus.next_state = MODIFIED;
        dir_bus.write      = 1'b1;
        flush              = 1'b1;
        step();
        idle();
        $display("tb: flush with write idx=64");
        chk("flush_init_drop", 32'(init_done), 32'd0);
        chk("flush_tag_zero", 32'(dir_bus.current_tag), 32'd0);
        wait_init(n);
        chk("flush_latency", 32'(n), 32'd128);
        rd_chk("flush_idx0", 0, '0, INVALID);
        rd_chk("flush_idx64", 64, '0, INVALID);
        rd_chk("flush_idx127", 127, '0, INVALID);

        // Reset at sweep cycle 50 restarts the sweep
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init(n);
        chk("rst_midsweep_latency", 32'(n), 32'd128);
        $display("tb: mid-sweep reset, init after %0d cycles", n);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            r     = int'($urandom_range(0, 999));
            rst   = (r < 5);
            flush = (r < 2) || (r >= 5 && r < 15);
            dir_bus.write = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 3) == 0)
                dir_bus.index = IW'($urandom_range(0, 127));
            else
                dir_bus.index = IW'($urandom_range(0, 7));
            dir_bus.next_tag   = TW'($urandom);
            dir_bus.next_state = line_state_t'($urandom_range(0, 3));
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
